// File: rtl/bcd_pkg.sv
// Shared types and constants for the BCD <-> binary converters.
package bcd_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } conv_state_t;

  localparam int         DIGIT_W    = 4;
  localparam logic [3:0] MAX_DIGIT  = 4'd9;
  localparam logic [3:0] ADJ_THRESH = 4'd8;
  localparam logic [3:0] ADJ_SUB    = 4'd3;

endpackage

// File: rtl/bcd_nibble_adjust.sv
// Reverse double-dabble digit correction: a nibble of 8 or more after the
// right shift carried in a half-ten from above, so subtract 3 to fix it.
module bcd_nibble_adjust
  import bcd_pkg::*;
(
  input  logic [DIGIT_W-1:0] nib,
  output logic [DIGIT_W-1:0] adj
);

  // conditional subtract-3 correction
  always_comb begin
    if (nib >= ADJ_THRESH) begin
      adj = nib - ADJ_SUB;
    end else begin
      adj = nib;
    end
  end

endmodule

// File: rtl/bcd_to_unsigned.sv
// Sequential packed-BCD to unsigned binary converter (reverse double-dabble).
// Optional macro BCD_CHECK_EN: reject inputs containing a nibble above 9.
module bcd_to_unsigned
  import bcd_pkg::*;
#(
  parameter int DIGITS = 8,
  parameter int OUT_W  = 32
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    trigger,
  input  logic [DIGIT_W*DIGITS-1:0] bcd,
  output logic                    idle,
  output logic                    done,
  output logic [OUT_W-1:0]        bin,
  output logic                    error
);

  localparam int BCD_W = DIGIT_W * DIGITS;
  localparam int SR_W  = BCD_W + OUT_W;
  localparam int CNT_W = $clog2(OUT_W + 1);

  conv_state_t      state_r, state_s;
  logic [SR_W-1:0]  sr_r, sr_s;
  logic [CNT_W-1:0] cnt_r, cnt_s;
  logic [OUT_W-1:0] bin_r, bin_s;
  logic             error_r, error_s;
  logic             idle_r, done_r;
  logic             invalid_s;
  logic [SR_W-1:0]  sr_shift_s;
  logic [BCD_W-1:0] bcd_adj_s;
  logic [SR_W-1:0]  sr_step_s;

`ifdef BCD_CHECK_EN
  function automatic logic has_invalid_digit(input logic [BCD_W-1:0] val);
    logic bad;
    bad = 1'b0;
    for (int i = 0; i < DIGITS; i++) begin
      if (val[DIGIT_W*i +: DIGIT_W] > MAX_DIGIT) begin
        bad = 1'b1;
      end else begin
        bad = bad;
      end
    end
    return bad;
  endfunction

  assign invalid_s = has_invalid_digit(bcd);
`else
  assign invalid_s = 1'b0;
`endif

  assign sr_shift_s = sr_r >> 1;

  for (genvar g = 0; g < DIGITS; g++) begin : g_adj
    bcd_nibble_adjust u_adj (
      .nib (sr_shift_s[OUT_W + DIGIT_W*g +: DIGIT_W]),
      .adj (bcd_adj_s[DIGIT_W*g +: DIGIT_W])
    );
  end

  // binary bits pass straight through; only the BCD half is corrected
  assign sr_step_s = {bcd_adj_s, sr_shift_s[OUT_W-1:0]};

  // next-state and datapath load selection
  always_comb begin
    state_s = state_r;
    sr_s    = sr_r;
    cnt_s   = cnt_r;
    bin_s   = bin_r;
    error_s = error_r;
    case (state_r)
      IDLE: begin
        if (trigger) begin
          if (invalid_s) begin
            bin_s   = {OUT_W{1'b0}};
            error_s = 1'b1;
            state_s = DONE;
          end else begin
            sr_s    = {bcd, {OUT_W{1'b0}}};
            cnt_s   = CNT_W'(OUT_W);
            state_s = SHIFT;
          end
        end else begin
          state_s = IDLE;
        end
      end
      SHIFT: begin
        sr_s  = sr_step_s;
        cnt_s = cnt_r - CNT_W'(1);
        if (cnt_r == CNT_W'(1)) begin
          bin_s   = sr_step_s[OUT_W-1:0];
          error_s = 1'b0;
          state_s = DONE;
        end else begin
          state_s = SHIFT;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // state, datapath and registered handshake outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r <= IDLE;
      sr_r    <= {SR_W{1'b0}};
      cnt_r   <= {CNT_W{1'b0}};
      bin_r   <= {OUT_W{1'b0}};
      error_r <= 1'b0;
      idle_r  <= 1'b1;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      sr_r    <= sr_s;
      cnt_r   <= cnt_s;
      bin_r   <= bin_s;
      error_r <= error_s;
      idle_r  <= (state_s == IDLE);
      done_r  <= (state_s == DONE);
    end
  end

  assign idle  = idle_r;
  assign done  = done_r;
  assign bin   = bin_r;
  assign error = error_r;

endmodule

// File: tb/tb_bcd_to_unsigned.sv
// Scoreboard bench for bcd_to_unsigned; expectations follow BCD_CHECK_EN.
module tb_bcd_to_unsigned;

  logic        clk;
  logic        reset;
  logic        trigger;
  logic [31:0] bcd;
  logic        idle;
  logic        done;
  logic [31:0] bin;
  logic        error;

  typedef struct {
    logic [31:0] bin;
    logic        err;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  int   cyc;
  int   n_checks;
  int   n_fail;

  bcd_to_unsigned #(.DIGITS(8), .OUT_W(32)) dut (
    .clk     (clk),
    .reset   (reset),
    .trigger (trigger),
    .bcd     (bcd),
    .idle    (idle),
    .done    (done),
    .bin     (bin),
    .error   (error)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // monitor: every done pulse must match the oldest outstanding expectation
  always @(negedge clk) begin
    if (!reset && done) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_done: got done=1 expected no pending result at cycle %0d", cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("bin", bin, e.bin);
        check("error", {31'd0, error}, {31'd0, e.err});
        check("latency", cyc, e.cyc);
      end
    end
  end

  task automatic start(input logic [31:0] v, input logic [31:0] eb, input logic ee, input int lat);
    int   n;
    exp_t e;
    n = 0;
    @(negedge clk);
    while (!idle && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!idle) begin
      n_checks++;
      n_fail++;
      $display("FAIL idle_timeout: got idle=0 expected idle=1 within 100 cycles");
    end
    e.bin = eb;
    e.err = ee;
    e.cyc = cyc + 1 + lat;
    exp_q.push_back(e);
    bcd     = v;
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
  endtask

  task automatic wait_done();
    int n;
    n = 0;
    @(negedge clk);
    while (!done && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!done) begin
      n_checks++;
      n_fail++;
      $display("FAIL done_timeout: got done=0 expected done=1 within 100 cycles");
    end
  endtask

  initial begin
    cyc      = 0;
    n_checks = 0;
    n_fail   = 0;
    reset    = 1'b1;
    trigger  = 1'b0;
    bcd      = 32'h0;
    repeat (2) @(negedge clk);
    check("rst_idle", {31'd0, idle}, 32'd1);
    check("rst_done", {31'd0, done}, 32'd0);
    check("rst_bin", bin, 32'd0);
    check("rst_error", {31'd0, error}, 32'd0);
    reset = 1'b0;

    // main conversion, idle handshake around it
    start(32'h12345678, 32'h00BC614E, 1'b0, 32);
    check("idle_falls", {31'd0, idle}, 32'd0);
    wait_done();
    @(negedge clk);
    check("idle_after_done", {31'd0, idle}, 32'd1);

    start(32'h99999999, 32'h05F5E0FF, 1'b0, 32);
    wait_done();
    start(32'h00000000, 32'h00000000, 1'b0, 32);
    wait_done();
    start(32'h00000001, 32'h00000001, 1'b0, 32);
    wait_done();

    // triggers during SHIFT are ignored; trigger right after done is accepted
    start(32'h00000042, 32'h0000002A, 1'b0, 32);
    repeat (4) @(negedge clk);
    bcd = 32'h00000099;
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    repeat (25) @(negedge clk);
    trigger = 1'b1;
    @(negedge clk);
    trigger = 1'b0;
    wait_done();
    start(32'h00000057, 32'h00000039, 1'b0, 32);
    wait_done();

    // bcd changed after the accepting edge
    start(32'h00000010, 32'h0000000A, 1'b0, 32);
    bcd = 32'h00000099;
    wait_done();

    // async reset mid-conversion aborts without done
    start(32'h00000123, 32'h0000007B, 1'b0, 32);
    wait_done();
    start(32'h00000456, 32'h000001C8, 1'b0, 32);
    repeat (9) @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("abort_bin", bin, 32'd0);
    check("abort_idle", {31'd0, idle}, 32'd1);
    void'(exp_q.pop_back());
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    start(32'h00000123, 32'h0000007B, 1'b0, 32);
    wait_done();

    // invalid digit
`ifdef BCD_CHECK_EN
    start(32'h0000001A, 32'h00000000, 1'b1, 0);
`else
    start(32'h0000001A, 32'h00000014, 1'b0, 32);
`endif
    wait_done();
    repeat (3) @(negedge clk);

    check("queue_empty", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/bcd_to_unsigned.md
Name: bcd_to_unsigned

Overview:
Sequential packed-BCD to unsigned-binary converter using reverse double-dabble: one right-shift plus per-nibble correction each clock. It is the inverse of unsigned_to_bcd and uses the same trigger/idle handshake. It sits between a BCD digit-entry path (switch nibbles or a keypad digit buffer) and the calculator ALU operand registers.

Parameters:
DIGITS, 8, number of packed BCD input digits (4 bits each).
OUT_W, 32, binary output width and iteration count; must satisfy 2^OUT_W > 10^DIGITS - 1 (DIGITS=8 needs at least 27).

Ports:
clk  input  1  system clock, rising edge.
reset  input  1  asynchronous, active-high reset.
trigger  input  1  start request; sampled only in IDLE; single-cycle pulse from debouncer posedge.
bcd  input  4*DIGITS  packed BCD value, digit 0 in bits [3:0]; captured on the accepting edge.
idle  output  1  high when ready to accept trigger.
done  output  1  one-cycle pulse when bin/error are updated.
bin  output  OUT_W  converted value; held until next done.
error  output  1  invalid-digit flag, updated with done; 0 when BCD_CHECK_EN is undefined.

Behaviour:
- Reset (async, any state): state=IDLE, idle=1, done=0, bin=0, error=0, shift register and counter cleared. Reset mid-conversion aborts with no done pulse.
- Datapath: shift register sr = {bcd_part[4*DIGITS], bin_part[OUT_W]}.
- IDLE: idle=1. When trigger=1 at an edge, load sr={bcd, 0}, load cnt=OUT_W, go to SHIFT.
- SHIFT: idle=0. Each edge: sr <= adjust(sr >> 1), cnt <= cnt-1.
  - adjust: each bcd_part nibble >= 8 gets 3 subtracted, all nibbles in parallel; bin_part passes unchanged.
  - On the edge where cnt==1, also load bin <= bin_part of the new sr, load error<=0, go to DONE.
- DONE: idle=0, done=1 for exactly one cycle, then IDLE.
- Latency: the sampling edge is edge 0. Shifts occur on edges 1..OUT_W. done is high in the cycle after edge OUT_W (32 cycles for the defaults).
- trigger asserted in SHIFT or DONE is ignored; it is neither queued nor restarted. A trigger in the first IDLE cycle after DONE is accepted.
- bcd changes after the accepting edge have no effect.
- bin and error change only on the edge that enters DONE.

Optional Feature:
BCD_CHECK_EN
- Defined: on the accepting edge, every nibble of bcd is compared against 9.
  - If any nibble exceeds 9: skip SHIFT, go directly to DONE with bin=0 and error=1; done is high in the cycle after edge 0.
  - Otherwise: normal conversion, error=0.
- Undefined: no check. Invalid nibbles are converted by the same algorithm, giving a deterministic but meaningless result. error is constant 0.

Decomposition:
- Package bcd_pkg:
  - typedef enum logic [1:0] {IDLE, SHIFT, DONE} conv_state_t.
  - localparam DIGIT_W=4, MAX_DIGIT=9, ADJ_THRESH=8, ADJ_SUB=3.
  - shared with unsigned_to_bcd.
- Sub-module bcd_nibble_adjust: combinational, 4-bit in to 4-bit out, subtracts 3 when input >= 8. Instantiated DIGITS times through a generate loop.

Test Plan:
1. bcd=32'h12345678, one trigger pulse: idle falls on the next cycle; done pulses 32 cycles after the sampling edge with bin=32'h00BC614E, error=0; idle=1 the following cycle.
2. bcd=32'h99999999 gives bin=32'h05F5E0FF. bcd=32'h00000000 gives bin=0. bcd=32'h00000001 gives bin=1. Each with done after exactly 32 cycles.
3. Trigger again at cycles 5 and 31 of a conversion of 32'h00000042: a single done, bin=32'h2A. A trigger in the cycle after done starts a new conversion.
4. Change bcd from 32'h00000010 to 32'h00000099 one cycle after trigger: result is bin=32'h0A.
5. Assert reset at cycle 10 of a conversion after a previous result of bin=32'h7B: bin=0, idle=1 immediately (async), and no done pulse. A later trigger with 32'h00000123 gives bin=32'h7B.
6. bcd=32'h0000001A:
   - With BCD_CHECK_EN: done in the cycle after edge 0, error=1, bin=0.
   - Without BCD_CHECK_EN: done after 32 cycles and error=0.
